// File: rtl/wbuf_rd_sched_if.sv
// Job config and per-cycle request bus between a read client and the
// weight-buffer read scheduler.
interface wbuf_rd_sched_if #(
    parameter int N_BANK = 6,
    parameter int DEPTH  = 11,
    parameter int LEN_W  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BID_W  = $clog2(N_BANK * DEPTH);
    localparam int BANK_W = $clog2(N_BANK);

    logic                        start;
    logic [3:0][BID_W-1:0]       cfg_base;
    logic [3:0][BID_W-1:0]       cfg_stride;
    logic [3:0]                  cfg_lane_en;
    logic [LEN_W-1:0]            cfg_len;
    logic                        stall;

    logic [3:0][BANK_W-1:0]      bank_sel;
    logic [3:0][ADDR_W-1:0]      addr_sel;
    logic [3:0]                  en_sel;
    logic [3:0]                  port_sel;
    logic [3:0]                  lane_vld;
    logic                        last;
    logic                        busy;
    logic                        done;
    logic                        err_oob;

    modport master (
        output start, cfg_base, cfg_stride, cfg_lane_en, cfg_len, stall,
        input  bank_sel, addr_sel, en_sel, port_sel, lane_vld, last, busy, done, err_oob
    );

    modport slave (
        input  start, cfg_base, cfg_stride, cfg_lane_en, cfg_len, stall,
        output bank_sel, addr_sel, en_sel, port_sel, lane_vld, last, busy, done, err_oob
    );
endinterface

// File: rtl/wbuf_rd_sched.sv
// Weight-buffer read scheduler: walks four strided block-id streams and
// maps them onto the 6-bank dual-port buffer, two lanes per bank per cycle.
module wbuf_rd_sched #(
    parameter int N_BANK = 6,
    parameter int DEPTH  = 11,
    parameter int LEN_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    wbuf_rd_sched_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BID_W  = $clog2(N_BANK * DEPTH);
    localparam int BANK_W = $clog2(N_BANK);
    localparam int N_LANE = 4;
    localparam logic [BID_W-1:0] ID_LIM  = BID_W'(N_BANK * DEPTH);
    localparam logic [BID_W-1:0] NB_ID   = BID_W'(N_BANK);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

    state_t state_q, state_d;

    logic [N_LANE-1:0][BID_W-1:0] acc, stride_q, acc_nxt;
    logic [N_LANE-1:0]            pend, lane_en_q, oob_base, oob_nxt;
    logic [N_LANE-1:0]            grant, port, en_sel, lane_vld;
    logic [N_BANK-1:0]            used_a, used_b;
    logic [BANK_W-1:0]            bk;
    logic [LEN_W-1:0]             len_q, step_cnt;
    logic                         accept, issue, step_fin, final_fin;
    logic                         last_q, err_q;

    // Next block ids and out-of-range flags for the first step and the next step.
    always_comb begin
        for (int j = 0; j < N_LANE; j++) begin
            acc_nxt[j]  = acc[j] + stride_q[j];
            oob_nxt[j]  = acc_nxt[j] >= ID_LIM;
            oob_base[j] = bus.cfg_base[j] >= ID_LIM;
        end
    end

    // In-order port arbitration: first lane on a bank gets A, second gets B, rest wait.
    always_comb begin
        used_a = '0;
        used_b = '0;
        grant  = '0;
        port   = '0;
        bk     = '0;
        for (int j = 0; j < N_LANE; j++) begin
            if (pend[j]) begin
                bk = BANK_W'(acc[j] % NB_ID);
                if (!used_a[bk]) begin
                    used_a[bk] = 1'b1;
                    grant[j]   = 1'b1;
                end else if (!used_b[bk]) begin
                    used_b[bk] = 1'b1;
                    grant[j]   = 1'b1;
                    port[j]    = 1'b1;
                end
            end
        end
    end

    assign accept    = (state_q == IDLE) && bus.start;
    assign issue     = (state_q == ISSUE) && !bus.stall && !rst;
    assign step_fin  = issue && ((pend & ~grant) == '0);
    assign final_fin = step_fin && (step_cnt == len_q - LEN_W'(1));
    assign en_sel    = issue ? grant : '0;

    // Request outputs; non-issuing lanes are forced to zero.
    always_comb begin
        for (int j = 0; j < N_LANE; j++) begin
            bus.bank_sel[j] = en_sel[j] ? BANK_W'(acc[j] % NB_ID) : '0;
            bus.addr_sel[j] = en_sel[j] ? ADDR_W'(acc[j] / NB_ID) : '0;
            bus.port_sel[j] = en_sel[j] & port[j];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            IDLE:  if (bus.start) state_d = (bus.cfg_len == '0) ? FLUSH : ISSUE;
            ISSUE: begin
                bus.busy = 1'b1;
                if (final_fin) state_d = FLUSH;
            end
            FLUSH: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job config, per-lane accumulators, pending mask and registered tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            stride_q  <= '0;
            lane_en_q <= '0;
            len_q     <= '0;
            step_cnt  <= '0;
            pend      <= '0;
            lane_vld  <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            lane_vld <= en_sel;
            last_q   <= 1'b0;
            if (accept) begin
                acc       <= bus.cfg_base;
                stride_q  <= bus.cfg_stride;
                lane_en_q <= bus.cfg_lane_en;
                len_q     <= bus.cfg_len;
                step_cnt  <= '0;
                err_q     <= |(bus.cfg_lane_en & oob_base);
                pend      <= (bus.cfg_len == '0) ? '0 : (bus.cfg_lane_en & ~oob_base);
                last_q    <= (bus.cfg_len == '0);
            end else if (final_fin) begin
                pend   <= '0;
                last_q <= 1'b1;
            end else if (step_fin) begin
                acc      <= acc_nxt;
                step_cnt <= step_cnt + LEN_W'(1);
                pend     <= lane_en_q & ~oob_nxt;
                if (|(lane_en_q & oob_nxt)) err_q <= 1'b1;
            end else if (issue) begin
                pend <= pend & ~grant;
            end
        end
    end

    assign bus.en_sel   = en_sel;
    assign bus.lane_vld = lane_vld;
    assign bus.last     = last_q;
    assign bus.err_oob  = err_q;
endmodule

// File: tb/tb_wbuf_rd_sched.sv
// Directed bench for wbuf_rd_sched with hand-computed request patterns.
module tb_wbuf_rd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    wbuf_rd_sched_if bus ();

    wbuf_rd_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pb(input int a, input int b, input int c, input int d);
        return {20'b0, 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [31:0] pa(input int a, input int b, input int c, input int d);
        return {16'b0, 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_iss(input string tag, input logic [3:0] en, input logic [31:0] bank,
                           input logic [31:0] addr, input logic [3:0] port);
        chk({tag, ".en"},   32'(bus.en_sel),   32'(en));
        chk({tag, ".bank"}, 32'(bus.bank_sel), bank);
        chk({tag, ".addr"}, 32'(bus.addr_sel), addr);
        chk({tag, ".port"}, 32'(bus.port_sel), 32'(port));
    endtask

    task automatic cfg(input int b0, input int b1, input int b2, input int b3,
                       input int s, input int len);
        bus.cfg_base    = {7'(b3), 7'(b2), 7'(b1), 7'(b0)};
        bus.cfg_stride  = {7'(s), 7'(s), 7'(s), 7'(s)};
        bus.cfg_lane_en = 4'hf;
        bus.cfg_len     = 8'(len);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        tick; tick;
        rst = 1'b0;
        #1;
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.last", 32'(bus.last), 0);
        chk("rst.vld",  32'(bus.lane_vld), 0);
        chk("rst.en",   32'(bus.en_sel), 0);
        chk("rst.err",  32'(bus.err_oob), 0);

        // Distinct banks
        tick; cfg(0, 1, 2, 3, 4, 3); bus.start = 1'b1; #1;
        chk("a0.busy", 32'(bus.busy), 0);
        tick; bus.start = 1'b0; #1;
        chk_iss("a1", 4'hf, pb(0, 1, 2, 3), pa(0, 0, 0, 0), 4'h0);
        chk("a1.busy", 32'(bus.busy), 1);
        tick; #1;
        chk_iss("a2", 4'hf, pb(4, 5, 0, 1), pa(0, 0, 1, 1), 4'h0);
        chk("a2.vld", 32'(bus.lane_vld), 32'hf);
        tick; #1;
        chk_iss("a3", 4'hf, pb(2, 3, 4, 5), pa(1, 1, 1, 1), 4'h0);
        tick; #1;
        chk("a4.en", 32'(bus.en_sel), 0);
        chk("a4.done", 32'(bus.done), 1);
        chk("a4.last", 32'(bus.last), 1);
        chk("a4.vld", 32'(bus.lane_vld), 32'hf);
        tick; #1;
        chk("a5.busy", 32'(bus.busy), 0);
        chk("a5.done", 32'(bus.done), 0);
        chk("a5.last", 32'(bus.last), 0);

        // Full conflict on bank 0
        cfg(0, 6, 12, 18, 24, 2); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk_iss("b1", 4'h3, pb(0, 0, 0, 0), pa(0, 1, 0, 0), 4'h2);
        tick; #1;
        chk_iss("b2", 4'hc, pb(0, 0, 0, 0), pa(0, 0, 2, 3), 4'h8);
        chk("b2.vld", 32'(bus.lane_vld), 32'h3);
        tick; #1;
        chk_iss("b3", 4'h3, pb(0, 0, 0, 0), pa(4, 5, 0, 0), 4'h2);
        tick; #1;
        chk_iss("b4", 4'hc, pb(0, 0, 0, 0), pa(0, 0, 6, 7), 4'h8);
        tick; #1;
        chk("b5.done", 32'(bus.done), 1);
        chk("b5.last", 32'(bus.last), 1);
        chk("b5.vld", 32'(bus.lane_vld), 32'hc);
        tick; #1;

        // Stall during c2-c3
        cfg(0, 1, 2, 3, 4, 3); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk_iss("c1", 4'hf, pb(0, 1, 2, 3), pa(0, 0, 0, 0), 4'h0);
        tick; bus.stall = 1'b1; #1;
        chk("c2.en", 32'(bus.en_sel), 0);
        chk("c2.vld", 32'(bus.lane_vld), 32'hf);
        tick; #1;
        chk("c3.en", 32'(bus.en_sel), 0);
        chk("c3.vld", 32'(bus.lane_vld), 0);
        chk("c3.busy", 32'(bus.busy), 1);
        tick; bus.stall = 1'b0; #1;
        chk_iss("c4", 4'hf, pb(4, 5, 0, 1), pa(0, 0, 1, 1), 4'h0);
        tick; #1;
        chk_iss("c5", 4'hf, pb(2, 3, 4, 5), pa(1, 1, 1, 1), 4'h0);
        chk("c5.vld", 32'(bus.lane_vld), 32'hf);
        tick; #1;
        chk("c6.done", 32'(bus.done), 1);
        tick; #1;

        // Out-of-range lane 3
        cfg(0, 1, 2, 70, 4, 3); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk("d1.err", 32'(bus.err_oob), 1);
        chk_iss("d1", 4'h7, pb(0, 1, 2, 0), pa(0, 0, 0, 0), 4'h0);
        tick; #1;
        chk_iss("d2", 4'h7, pb(4, 5, 0, 0), pa(0, 0, 1, 0), 4'h0);
        tick; #1;
        chk_iss("d3", 4'h7, pb(2, 3, 4, 0), pa(1, 1, 1, 0), 4'h0);
        tick; #1;
        chk("d4.done", 32'(bus.done), 1);
        tick; #1;
        chk("d5.busy", 32'(bus.busy), 0);
        chk("d5.err", 32'(bus.err_oob), 1);

        // Zero-length job clears err_oob
        cfg(0, 1, 2, 3, 4, 0); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk("e1.err", 32'(bus.err_oob), 0);
        chk("e1.done", 32'(bus.done), 1);
        chk("e1.last", 32'(bus.last), 1);
        chk("e1.en", 32'(bus.en_sel), 0);
        tick; #1;
        chk("e2.busy", 32'(bus.busy), 0);
        chk("e2.vld", 32'(bus.lane_vld), 0);

        // Start during ISSUE is ignored
        cfg(0, 1, 2, 3, 4, 3); bus.start = 1'b1; #1;
        tick; cfg(5, 5, 5, 5, 1, 3); #1;
        chk_iss("f1", 4'hf, pb(0, 1, 2, 3), pa(0, 0, 0, 0), 4'h0);
        tick; bus.start = 1'b0; #1;
        chk_iss("f2", 4'hf, pb(4, 5, 0, 1), pa(0, 0, 1, 1), 4'h0);
        tick; #1;
        chk_iss("f3", 4'hf, pb(2, 3, 4, 5), pa(1, 1, 1, 1), 4'h0);
        tick; #1;
        chk("f4.done", 32'(bus.done), 1);
        tick; #1;

        // Reset mid-job
        cfg(0, 1, 2, 70, 4, 3); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk("g1.err", 32'(bus.err_oob), 1);
        tick; rst = 1'b1; #1;
        chk("g2.en", 32'(bus.en_sel), 0);
        tick; rst = 1'b0; #1;
        chk("g3.busy", 32'(bus.busy), 0);
        chk("g3.err", 32'(bus.err_oob), 0);
        chk("g3.done", 32'(bus.done), 0);
        chk("g3.vld", 32'(bus.lane_vld), 0);
        tick; #1;
        chk("g4.done", 32'(bus.done), 0);
        cfg(0, 1, 2, 3, 4, 3); bus.start = 1'b1; #1;
        tick; bus.start = 1'b0; #1;
        chk_iss("h1", 4'hf, pb(0, 1, 2, 3), pa(0, 0, 0, 0), 4'h0);
        tick; tick; tick; #1;
        chk("h4.done", 32'(bus.done), 1);
        chk("h4.last", 32'(bus.last), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
